// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives imem, and buffers {pc, insn}
// pairs in a DEPTH-entry FIFO toward decode, with redirect/flush and counters.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              CNT_W    = 32,
    parameter int              PC_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_en,
    output logic [XLEN-1:0]  imem_addr,
    output logic             imem_en,
    input  logic [XLEN-1:0]  imem_insn,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_insn,
    output logic [XLEN-1:0]  id_pc,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]    LAST_IDX   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_BITS-1:0] DEPTH_C    = CNT_BITS'(DEPTH);
    localparam logic [XLEN-1:0]     STEP_C     = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0]     ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0]     pc_r;
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [CNT_BITS-1:0] count_r;
    logic [XLEN-1:0]     insn_q_r [DEPTH];
    logic [XLEN-1:0]     pc_q_r   [DEPTH];
    logic [CNT_W-1:0]    cyc_r;
    logic [CNT_W-1:0]    fetch_r;
    logic                pop_s;
    logic                push_s;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Handshake decode: a full queue may still accept when the head leaves.
    always_comb begin
        pop_s  = (count_r != {CNT_BITS{1'b0}}) & id_ready;
        push_s = fetch_en & ~redirect_valid & ((count_r < DEPTH_C) | pop_s);
    end

    // PC, queue storage, pointers and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_BITS{1'b0}};
            cyc_r   <= {CNT_W{1'b0}};
            fetch_r <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                insn_q_r[i] <= {XLEN{1'b0}};
                pc_q_r[i]   <= {XLEN{1'b0}};
            end
        end else begin
            cyc_r <= cyc_r + CNT_W'(1);
            if (redirect_valid) begin
                // A same-cycle pop is irrelevant: the flush empties everything.
                head_r  <= {PTR_W{1'b0}};
                tail_r  <= {PTR_W{1'b0}};
                count_r <= {CNT_BITS{1'b0}};
                pc_r    <= redirect_pc & ALIGN_MASK;
            end else begin
                if (pop_s) begin
                    head_r <= next_ptr(head_r);
                end else begin
                    head_r <= head_r;
                end
                if (push_s) begin
                    insn_q_r[tail_r] <= imem_insn;
                    pc_q_r[tail_r]   <= pc_r;
                    tail_r           <= next_ptr(tail_r);
                    pc_r             <= pc_r + STEP_C;
                    fetch_r          <= fetch_r + CNT_W'(1);
                end else begin
                    pc_r <= pc_r;
                end
                count_r <= count_r + CNT_BITS'(push_s) - CNT_BITS'(pop_s);
            end
        end
    end

    assign imem_addr = pc_r;
    assign imem_en   = push_s;
    assign id_valid  = (count_r != {CNT_BITS{1'b0}});
    assign id_insn   = insn_q_r[head_r];
    assign id_pc     = pc_q_r[head_r];
    assign cyc_cnt   = cyc_r;
    assign fetch_cnt = fetch_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model compared every
// cycle, plus literal expectations at key points of the scenario.
module tb_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_insn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_insn;
    logic [31:0] id_pc;
    logic [31:0] cyc_cnt;
    logic [31:0] fetch_cnt;

    int vectors    = 0;
    int miscompares = 0;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .CNT_W(32), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_insn(imem_insn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_insn(id_insn), .id_pc(id_pc),
        .cyc_cnt(cyc_cnt), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory: every word reads as its address + 0x100.
    assign imem_insn = imem_addr + 32'h100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, insn} plus the architectural PC and counters.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_cyc;
    logic [31:0] m_fetch;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_pc     = 32'h0;
            m_cyc    = 32'h0;
            m_fetch  = 32'h0;
            model_ok = 1'b1;
        end else begin
            automatic bit pop  = (mq.size() != 0) && id_ready;
            automatic bit push = fetch_en && !redirect_valid && ((mq.size() < DEPTH) || pop);
            m_cyc = m_cyc + 32'd1;
            if (pop) void'(mq.pop_front());
            if (redirect_valid) begin
                mq.delete();
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (push) begin
                mq.push_back('{pc: m_pc, insn: m_pc + 32'h100});
                m_pc    = m_pc + 32'd4;
                m_fetch = m_fetch + 32'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            automatic bit v  = (mq.size() != 0);
            automatic bit en = fetch_en && !redirect_valid && ((mq.size() < DEPTH) || (v && id_ready));
            chk("m_id_valid", {63'd0, id_valid}, {63'd0, v});
            chk("m_imem_addr", {32'd0, imem_addr}, {32'd0, m_pc});
            chk("m_imem_en", {63'd0, imem_en}, {63'd0, en});
            chk("m_cyc_cnt", {32'd0, cyc_cnt}, {32'd0, m_cyc});
            chk("m_fetch_cnt", {32'd0, fetch_cnt}, {32'd0, m_fetch});
            if (v) begin
                chk("m_id_pc", {32'd0, id_pc}, {32'd0, mq[0].pc});
                chk("m_id_insn", {32'd0, id_insn}, {32'd0, mq[0].insn});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [23:0] pat_ready = 24'b1011_0011_1100_0101_1110_0110;
    logic [23:0] pat_fetch = 24'b1111_1010_0111_1111_0011_1101;

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) tick();
        chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
        chk("rst_id_insn", {32'd0, id_insn}, 64'd0);
        chk("rst_id_pc", {32'd0, id_pc}, 64'd0);
        chk("rst_cyc", {32'd0, cyc_cnt}, 64'd0);
        chk("rst_fetch", {32'd0, fetch_cnt}, 64'd0);

        // Streaming at one instruction per cycle.
        rst_n = 1'b1; fetch_en = 1'b1; id_ready = 1'b1;
        #1;
        chk("c1_imem_addr", {32'd0, imem_addr}, 64'h0);
        chk("c1_imem_en", {63'd0, imem_en}, 64'd1);
        tick();
        chk("c2_id_pc", {32'd0, id_pc}, 64'h0);
        chk("c2_id_insn", {32'd0, id_insn}, 64'h100);
        tick();
        chk("c3_id_pc", {32'd0, id_pc}, 64'h4);
        chk("c3_id_insn", {32'd0, id_insn}, 64'h104);
        tick();
        chk("c4_id_pc", {32'd0, id_pc}, 64'h8);
        chk("c4_id_insn", {32'd0, id_insn}, 64'h108);
        tick();
        chk("cyc_after_4", {32'd0, cyc_cnt}, 64'd4);

        // Back-pressure from an empty start: two pushes then hold.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; id_ready = 1'b0;
        repeat (5) tick();
        chk("stall_pc", {32'd0, imem_addr}, 64'h8);
        chk("stall_en", {63'd0, imem_en}, 64'd0);
        chk("stall_fetch", {32'd0, fetch_cnt}, 64'd2);
        chk("stall_head", {32'd0, id_pc}, 64'h0);
        id_ready = 1'b1;
        #1;
        chk("full_pop_en", {63'd0, imem_en}, 64'd1);
        tick();
        chk("drain_pc4", {32'd0, id_pc}, 64'h4);
        tick();
        chk("drain_pc8", {32'd0, id_pc}, 64'h8);
        tick();
        chk("drain_pc12", {32'd0, id_pc}, 64'hC);
        chk("drain_fetch", {32'd0, fetch_cnt}, 64'd5);

        // Redirect while full, unaligned target.
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h203;
        #1;
        chk("redir_no_push", {63'd0, imem_en}, 64'd0);
        tick();
        chk("redir_addr", {32'd0, imem_addr}, 64'h200);
        chk("redir_valid0", {63'd0, id_valid}, 64'd0);
        redirect_valid = 1'b0;
        tick();
        chk("redir_head", {32'd0, id_pc}, 64'h200);
        chk("redir_insn", {32'd0, id_insn}, 64'h300);

        // Redirect concurrent with a pop, then back-to-back redirects.
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        chk("rpop_valid0", {63'd0, id_valid}, 64'd0);
        chk("rpop_addr", {32'd0, imem_addr}, 64'h500);
        redirect_pc = 32'h600;
        tick();
        redirect_pc = 32'h704;
        tick();
        chk("b2b_addr", {32'd0, imem_addr}, 64'h704);
        redirect_valid = 1'b0;
        tick();
        chk("b2b_head", {32'd0, id_pc}, 64'h704);

        // fetch_en low with two entries queued.
        id_ready = 1'b0;
        tick();
        fetch_en = 1'b0; id_ready = 1'b1;
        #1;
        chk("fen0_en", {63'd0, imem_en}, 64'd0);
        tick();
        chk("fen0_head", {32'd0, id_pc}, 64'h708);
        tick();
        chk("fen0_empty", {63'd0, id_valid}, 64'd0);
        chk("fen0_pc", {32'd0, imem_addr}, 64'h70C);
        chk("fen0_en2", {63'd0, imem_en}, 64'd0);

        // Reset mid-stream.
        fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        chk("pre_rst_pc", {32'd0, imem_addr}, 64'h40);
        redirect_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_addr", {32'd0, imem_addr}, 64'h0);
        chk("mid_rst_valid", {63'd0, id_valid}, 64'd0);
        chk("mid_rst_cyc", {32'd0, cyc_cnt}, 64'd0);
        chk("mid_rst_fetch", {32'd0, fetch_cnt}, 64'd0);

        // PC wrap at the top of the address space.
        rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_head", {32'd0, id_pc}, 64'hFFFF_FFFC);
        chk("wrap_insn", {32'd0, id_insn}, 64'hFC);
        chk("wrap_addr", {32'd0, imem_addr}, 64'h0);
        tick();
        chk("wrap_next", {32'd0, id_pc}, 64'h0);

        // Mixed handshake pattern checked by the model alone.
        for (int i = 0; i < 24; i++) begin
            id_ready       = pat_ready[i];
            fetch_en       = pat_fetch[i];
            redirect_valid = (i == 10) || (i == 17);
            redirect_pc    = 32'h1000 + 32'(i);
            tick();
        end
        redirect_valid = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
